// File: rtl/sync_filter_bus.sv
// sync_filter_bus: per-channel flop-chain synchroniser followed by a debounce filter.
// Define SYNC_FILTER_BUS_EDGE_EN to build the registered rise/fall pulse outputs.
module sync_filter_bus #(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] synch_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int               CNT_W    = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [STAGES-1:0] chain_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic [CNT_W-1:0]  cnt_next;
      logic              out_reg;
      logic              out_next;
      logic              stable;

      // Only chain_reg[0] ever sees the asynchronous input.
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_reg <= {STAGES{RESET_VAL[gi]}};
        end else begin
          chain_reg <= {chain_reg[STAGES-2:0], async_in[gi]};
        end
      end

      assign stable = chain_reg[STAGES-1];

      // Any return to the current output level restarts the count.
      always_comb begin
        cnt_next = cnt_reg;
        out_next = out_reg;
        if (stable == out_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          out_next = stable;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          out_reg <= RESET_VAL[gi];
          cnt_reg <= '0;
        end else begin
          out_reg <= out_next;
          cnt_reg <= cnt_next;
        end
      end

      assign synch_out[gi] = out_reg;

`ifdef SYNC_FILTER_BUS_EDGE_EN
      logic rise_reg;
      logic fall_reg;

      // Pulses are registered alongside out_reg so they coincide with the new level.
      always_ff @(posedge clk) begin
        if (reset) begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= out_next & ~out_reg;
          fall_reg <= ~out_next & out_reg;
        end
      end

      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;
`else
      assign rise[gi] = 1'b0;
      assign fall[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_sync_filter_bus.sv
// Bench for sync_filter_bus: four differently configured instances share one stimulus bus
// and are checked every cycle against a window-based model plus hand-computed points.
module tb_sync_filter_bus;

  localparam int         NI = 4;
  localparam int         ST_P [NI] = '{2, 3, 2, 4};
  localparam int         FL_P [NI] = '{1, 4, 5, 8};
  localparam logic [3:0] RV_P [NI] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
  localparam int         LAST_EDGE = 125;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] async_in;
  logic [3:0] so [NI];
  logic [3:0] ri [NI];
  logic [3:0] fa [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      sync_filter_bus #(
        .WIDTH     (4),
        .STAGES    (ST_P[gi]),
        .FILTER_LEN(FL_P[gi]),
        .RESET_VAL (RV_P[gi])
      ) dut (
        .clk      (clk),
        .reset    (reset),
        .async_in (async_in),
        .synch_out(so[gi]),
        .rise     (ri[gi]),
        .fall     (fa[gi])
      );
    end
  endgenerate

  // History of what every posedge sampled; edge numbering starts at 1.
  int         cyc = 0;
  logic [3:0] a_hist [0:255];
  bit         r_hist [0:255];

  always @(posedge clk) begin
    cyc             <= cyc + 1;
    a_hist[cyc + 1] <= async_in;
    r_hist[cyc + 1] <= reset;
  end

  int checks = 0;
  int errors = 0;

  logic [3:0] m_so [NI];
  logic [3:0] m_ri [NI];
  logic [3:0] m_fa [NI];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  // Level the filter sees at edge j: input sampled STAGES edges earlier, unless a reset
  // landed in between, in which case the chain still holds its reset level.
  function automatic logic f_val(int j, int st, logic rv, int ch);
    if (j - st < 1) return rv;
    for (int m = j - st; m < j; m++)
      if (r_hist[m]) return rv;
    return a_hist[j - st][ch];
  endfunction

  // An output bit adopts level v at edge t when the filter saw v (differing from the
  // current output) on each of the last FILTER_LEN edges with no reset among them.
  task automatic model_step(input int p, input int t);
    logic [3:0] prev, nxt;
    logic       v, ok;
    if (r_hist[t]) begin
      m_so[p] = RV_P[p];
      m_ri[p] = 4'b0;
      m_fa[p] = 4'b0;
    end else begin
      prev = m_so[p];
      nxt  = prev;
      for (int ch = 0; ch < 4; ch++) begin
        ok = (t - FL_P[p] + 1 >= 1);
        for (int k = 0; k < FL_P[p] && ok; k++)
          if (r_hist[t - k]) ok = 1'b0;
        if (ok) begin
          v = f_val(t, ST_P[p], RV_P[p][ch], ch);
          for (int k = 1; k < FL_P[p]; k++)
            if (f_val(t - k, ST_P[p], RV_P[p][ch], ch) != v) ok = 1'b0;
          if (ok) nxt[ch] = v;
        end
      end
      m_ri[p] = nxt & ~prev;
      m_fa[p] = ~nxt & prev;
      m_so[p] = nxt;
    end
  endtask

  function automatic logic [3:0] pulse_exp(input logic [3:0] v);
`ifdef SYNC_FILTER_BUS_EDGE_EN
    return v;
`else
    return 4'b0 & v;
`endif
  endfunction

  // Hand-computed point checks on both the DUT and the model.
  task automatic lit(input string nm, input int p, input int ch, input int kind, input logic exp);
    logic [3:0] d, m;
    case (kind)
      0:       begin d = so[p]; m = m_so[p];            end
      1:       begin d = ri[p]; m = pulse_exp(m_ri[p]); end
      default: begin d = fa[p]; m = pulse_exp(m_fa[p]); end
    endcase
    chk({nm, "_dut"}, {3'b0, d[ch]}, {3'b0, exp});
    chk({nm, "_model"}, {3'b0, m[ch]}, {3'b0, exp});
  endtask

  task automatic lit4(input string nm, input int p, input int kind, input logic [3:0] exp);
    for (int ch = 0; ch < 4; ch++) lit($sformatf("%s[%0d]", nm, ch), p, ch, kind, exp[ch]);
  endtask

  logic pe;

  initial begin
`ifdef SYNC_FILTER_BUS_EDGE_EN
    pe = 1'b1;
`else
    pe = 1'b0;
`endif
    reset    = 1'b1;
    async_in = 4'b0101;
    while (cyc < LAST_EDGE) begin
      @(negedge clk);
      for (int p = 0; p < NI; p++) begin
        model_step(p, cyc);
        chk($sformatf("synch_out_i%0d", p), so[p], m_so[p]);
        chk($sformatf("rise_i%0d", p), ri[p], pulse_exp(m_ri[p]));
        chk($sformatf("fall_i%0d", p), fa[p], pulse_exp(m_fa[p]));
      end

      case (cyc)
        2:  begin lit4("rst_so_i0", 0, 0, 4'b1010); lit4("rst_rise_i0", 0, 1, 4'b0);
                  lit4("rst_fall_i0", 0, 2, 4'b0); end
        5:  lit4("pre_so_i0", 0, 0, 4'b1010);
        6:  begin lit4("rel_so_i0", 0, 0, 4'b0101);
                  lit4("rel_rise_i0", 0, 1, pe ? 4'b0101 : 4'b0000);
                  lit4("rel_fall_i0", 0, 2, pe ? 4'b1010 : 4'b0000); end
        7:  begin lit4("rel_rise_off_i0", 0, 1, 4'b0); lit4("rel_fall_off_i0", 0, 2, 4'b0); end
        35: lit("lat_so_early_i1", 1, 3, 0, 1'b0);
        36: begin lit("lat_so_i1", 1, 3, 0, 1'b1); lit("lat_rise_i1", 1, 3, 1, pe); end
        37: lit("lat_rise_off_i1", 1, 3, 1, 1'b0);
        48: begin lit("glitch_so_i1", 1, 1, 0, 1'b0); lit("glitch_rise_i1", 1, 1, 1, 1'b0); end
        56: begin lit("pulse_so_i1", 1, 1, 0, 1'b1); lit("pulse_rise_i1", 1, 1, 1, pe); end
        60: begin lit("pulse_so_low_i1", 1, 1, 0, 1'b0); lit("pulse_fall_i1", 1, 1, 2, pe); end
        79: lit("restart_so_early_i2", 2, 1, 0, 1'b0);
        80: begin lit("restart_so_i2", 2, 1, 0, 1'b1); lit("restart_rise_i2", 2, 1, 1, pe); end
        84: begin lit4("midrst_so_i3", 3, 0, 4'b0000); lit4("midrst_rise_i3", 3, 1, 4'b0); end
        95: lit("midrst_so_early_i3", 3, 1, 0, 1'b0);
        96: lit("midrst_so_i3", 3, 1, 0, 1'b1);
        default: ;
      endcase

      case (cyc)
        3:  reset = 1'b0;
        29: async_in[3] = 1'b1;
        39: async_in[1] = 1'b1;
        42: async_in[1] = 1'b0;
        49: async_in[1] = 1'b1;
        53: async_in[1] = 1'b0;
        69: async_in[1] = 1'b1;
        72: async_in[1] = 1'b0;
        73: async_in[1] = 1'b1;
        83: reset = 1'b1;
        84: reset = 1'b0;
        default: begin
          if (cyc >= 99 && cyc <= 114) begin
            if (cyc % 2 == 1) async_in[0] = ~async_in[0];
            if (cyc % 6 == 0) async_in[2] = ~async_in[2];
          end
        end
      endcase
      $display("edge %0d: reset=%b async_in=%b out0=%b out1=%b out2=%b out3=%b",
               cyc, reset, async_in, so[0], so[1], so[2], so[3]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
